// File: rtl/mem_port_arbiter.sv
// Arbitrates one unified memory port between instruction fetch and the MEM stage.
// MEM has priority; a completing requester hands the bus straight to the waiting one.
module mem_port_arbiter #(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter logic [2:0]  IF_RWTYPE = 3'b010
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [2:0]        mem_rwtype,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              bus_req,
  output logic              bus_we,
  output logic [2:0]        bus_rwtype,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ready,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IF  = 2'd1,
    BUSY_MEM = 2'd2
  } state_t;

  state_t state, state_nx;
  logic   killed, killed_nx;
  logic   load_if, load_mem;
  logic   if_done, mem_done;

  // Handshake: requesters hold req (and fields) until their valid strobe; a bus
  // transaction completes on a rising edge where bus_req & bus_ready, and
  // bus_ready is ignored while bus_req is low.
  assign if_done  = (state == BUSY_IF)  & bus_ready;
  assign mem_done = (state == BUSY_MEM) & bus_ready;

  always_comb begin
    state_nx  = state;
    killed_nx = killed;
    load_if   = 1'b0;
    load_mem  = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req) begin
          state_nx = BUSY_MEM;
          load_mem = 1'b1;
        end else if (if_req & ~if_kill) begin
          state_nx = BUSY_IF;
          load_if  = 1'b1;
        end
      end
      BUSY_IF: begin
        if (bus_ready) begin
          killed_nx = 1'b0;
          if (mem_req) begin
            state_nx = BUSY_MEM;
            load_mem = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end else if (if_kill) begin
          killed_nx = 1'b1;
        end
      end
      BUSY_MEM: begin
        if (bus_ready) begin
          if (if_req & ~if_kill) begin
            state_nx = BUSY_IF;
            load_if  = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      killed     <= 1'b0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_rwtype <= 3'b000;
      bus_addr   <= '0;
      bus_wdata  <= '0;
    end else begin
      state   <= state_nx;
      killed  <= killed_nx;
      bus_req <= (state_nx != IDLE);
      if (load_mem) begin
        bus_we     <= mem_we;
        bus_rwtype <= mem_rwtype;
        bus_addr   <= mem_addr;
        bus_wdata  <= mem_wdata;
      end else if (load_if) begin
        bus_we     <= 1'b0;
        bus_rwtype <= IF_RWTYPE;
        bus_addr   <= if_addr;
        bus_wdata  <= '0;
      end
    end
  end

  // A killed fetch still finishes on the bus but never reports to IF.
  assign if_valid  = if_done & ~killed & ~if_kill;
  assign mem_valid = mem_done;
  assign if_rdata  = if_valid  ? bus_rdata : '0;
  assign mem_rdata = mem_valid ? bus_rdata : '0;
  assign stall_if  = if_req  & ~if_valid;
  assign stall_mem = mem_req & ~mem_valid;
  assign dbg_state = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: requester agents, a wait-stating memory
// responder, a transaction-level ownership model and a data scoreboard.
module tb_mem_port_arbiter;

  localparam int         AW  = 32;
  localparam int         DW  = 32;
  localparam logic [2:0] IFT = 3'b010;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_kill, if_valid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          mem_req, mem_we, mem_valid;
  logic [2:0]    mem_rwtype;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          stall_if, stall_mem;
  logic          bus_req, bus_we, bus_ready;
  logic [2:0]    bus_rwtype;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata, bus_rdata;
  logic [1:0]    dbg_state;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] if_exp_q[$];
  logic [DW:0]   mem_exp_q[$];
  logic [DW-1:0] bus_mem[logic [AW-1:0]];
  logic [DW-1:0] ref_mem[logic [AW-1:0]];
  int            fixed_wait = -1;
  int            waits_left = -1;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .IF_RWTYPE(IFT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_rwtype(mem_rwtype),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .bus_req(bus_req), .bus_we(bus_we), .bus_rwtype(bus_rwtype),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata),
    .dbg_state(dbg_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  function automatic logic [DW-1:0] bus_rd(input logic [AW-1:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : rom(a);
  endfunction

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : rom(a);
  endfunction

  // Memory responder: random (or fixed) wait states per transaction.
  initial begin
    bus_ready = 1'b0;
    bus_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (rst || !bus_req) begin
        waits_left = -1;
        bus_ready  = ($urandom_range(0, 1) == 1);
        bus_rdata  = $urandom;
      end else begin
        if (waits_left < 0)
          waits_left = (fixed_wait >= 0) ? fixed_wait : $urandom_range(0, 3);
        if (waits_left == 0) begin
          bus_ready = 1'b1;
          bus_rdata = bus_rd(bus_addr);
          if (bus_we) bus_mem[bus_addr] = bus_wdata;
          waits_left = -1;
        end else begin
          bus_ready = 1'b0;
          bus_rdata = $urandom;
          waits_left--;
        end
      end
    end
  end

  // Ownership model: who holds the bus, with which fields, and who completes.
  initial begin
    int            owner;
    int            prev;
    bit            m_killed;
    bit            done, exp_if_v, exp_mem_v;
    logic          m_we;
    logic [2:0]    m_rwt;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    owner = 0;
    m_killed = 1'b0;
    m_we = 1'b0; m_rwt = '0; m_addr = '0; m_wdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        owner    = 0;
        m_killed = 1'b0;
        check("rst_bus_req", bus_req, 0);
        check("rst_bus_we", bus_we, 0);
        check("rst_bus_rwtype", bus_rwtype, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_bus_wdata", bus_wdata, 0);
        check("rst_if_valid", if_valid, 0);
        check("rst_mem_valid", mem_valid, 0);
      end else begin
        done      = (owner != 0) && bus_ready;
        exp_if_v  = done && owner == 1 && !m_killed && !if_kill;
        exp_mem_v = done && owner == 2;
        check("bus_req", bus_req, owner != 0);
        if (owner != 0) begin
          check("bus_we", bus_we, m_we);
          check("bus_rwtype", bus_rwtype, m_rwt);
          check("bus_addr", bus_addr, m_addr);
          check("bus_wdata", bus_wdata, m_wdata);
        end
        check("if_valid", if_valid, exp_if_v);
        check("mem_valid", mem_valid, exp_mem_v);
        check("stall_if", stall_if, if_req && !exp_if_v);
        check("stall_mem", stall_mem, mem_req && !exp_mem_v);
        if (owner == 1 && !done && if_kill) m_killed = 1'b1;
        if (done) m_killed = 1'b0;
        if (owner == 0 || done) begin
          prev  = owner;
          owner = 0;
          if (mem_req && prev != 2) begin
            owner = 2;
            m_we = mem_we; m_rwt = mem_rwtype; m_addr = mem_addr; m_wdata = mem_wdata;
          end else if (if_req && !if_kill && prev != 1) begin
            owner = 1;
            m_we = 1'b0; m_rwt = IFT; m_addr = if_addr; m_wdata = '0;
          end
        end
      end
    end
  end

  // Scoreboard monitor: pops an expected response whenever a valid appears.
  initial begin
    logic [DW-1:0] e;
    logic [DW:0]   me;
    forever begin
      @(negedge clk); #1;
      if (if_valid) begin
        check("if_pending", if_exp_q.size() != 0, 1);
        if (if_exp_q.size() != 0) begin
          e = if_exp_q.pop_front();
          check("if_rdata", if_rdata, e);
        end
      end else begin
        check("if_rdata_idle", if_rdata, 0);
      end
      if (mem_valid) begin
        check("mem_pending", mem_exp_q.size() != 0, 1);
        if (mem_exp_q.size() != 0) begin
          me = mem_exp_q.pop_front();
          if (me[DW]) check("mem_rdata", mem_rdata, me[DW-1:0]);
        end
      end else begin
        check("mem_rdata_idle", mem_rdata, 0);
      end
    end
  end

  // IF agent: kill_after > 0 kills the fetch that many cycles after issue.
  task automatic fetch(input logic [AW-1:0] a, input int kill_after);
    bit got;
    int n;
    got = 1'b0;
    n   = 0;
    if_req  = 1'b1;
    if_addr = a;
    if_exp_q.push_back(rom(a));
    while (!got && n < 64) begin
      @(negedge clk);
      got = if_valid;
      @(posedge clk); #1;
      n++;
      if (!got && kill_after > 0 && n == kill_after) begin
        if_kill = 1'b1;
        if_req  = 1'b0;
        void'(if_exp_q.pop_back());
        @(posedge clk); #1;
        if_kill = 1'b0;
        return;
      end
    end
    if (!got) begin
      check("if_timeout", got, 1);
      if_exp_q.delete();
    end
    if_req = 1'b0;
  endtask

  task automatic mem_op(input logic we, input logic [2:0] rwt,
                        input logic [AW-1:0] a, input logic [DW-1:0] wd);
    bit got;
    int n;
    got = 1'b0;
    n   = 0;
    mem_req = 1'b1; mem_we = we; mem_rwtype = rwt; mem_addr = a; mem_wdata = wd;
    if (we) begin
      mem_exp_q.push_back({1'b0, {DW{1'b0}}});
      ref_mem[a] = wd;
    end else begin
      mem_exp_q.push_back({1'b1, ref_rd(a)});
    end
    while (!got && n < 64) begin
      @(negedge clk);
      got = mem_valid;
      @(posedge clk); #1;
      n++;
    end
    if (!got) begin
      check("mem_timeout", got, 1);
      mem_exp_q.delete();
    end
    mem_req = 1'b0;
  endtask

  task automatic reset_mid_load();
    fixed_wait = 5;
    mem_req = 1'b1; mem_we = 1'b0; mem_rwtype = 3'b010;
    mem_addr = 32'h0000_2040; mem_wdata = '0;
    mem_exp_q.push_back({1'b1, ref_rd(32'h0000_2040)});
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_bus_req", bus_req, 1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_bus_req", bus_req, 0);
    check("async_rst_bus_addr", bus_addr, 0);
    mem_req = 1'b0;
    void'(mem_exp_q.pop_back());
    @(posedge clk); #2;
    rst = 1'b0;
    fixed_wait = -1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0; if_kill = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_rwtype = '0; mem_addr = '0; mem_wdata = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    fixed_wait = 0;
    fetch(32'h0000_0100, 0);
    fork
      fetch(32'h0000_0104, 0);
      mem_op(1'b1, 3'b010, 32'h0000_2000, 32'hDEAD_BEEF);
    join
    mem_op(1'b0, 3'b010, 32'h0000_2000, '0);
    fixed_wait = 3;
    mem_op(1'b0, 3'b010, 32'h0000_0040, '0);
    fixed_wait = 2;
    fetch(32'h0000_0200, 2);
    fixed_wait = 0;
    fetch(32'h0000_0300, 0);
    fork
      for (int i = 0; i < 4; i++) fetch(32'h0000_0400 + 32'(i * 4), 0);
      for (int j = 0; j < 4; j++) mem_op(1'b1, 3'b000, 32'h0000_2100 + 32'(j * 4), $urandom);
    join
    reset_mid_load();
    fetch(32'h0000_0180, 0);

    fixed_wait = -1;
    fork
      for (int i = 0; i < 80; i++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        fetch(32'h0000_0100 + 32'($urandom_range(0, 500) * 4),
              ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 4)) : 0);
      end
      for (int j = 0; j < 80; j++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        mem_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               32'h0000_2000 + 32'($urandom_range(0, 15) * 4), $urandom);
      end
    join

    repeat (5) @(posedge clk);
    #1;
    check("if_q_drained", if_exp_q.size(), 0);
    check("mem_q_drained", mem_exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
